knn_ctrl: RTL

- CPU-side controller for knn_core: an iob native-bus slave that drives knn_core's enable/sample inputs and reads back its 2*DATA_W value.
- Turns register writes into a single-cycle KNN_SAMPLE pulse, captures the sampled value into a snapshot, and returns it as two DATA_W words with a coherent lo-then-hi read.
- Sits between the system interconnect and knn_core.

---
 rtl/knn_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/knn_ctrl.sv
// knn_ctrl: iob native-bus slave driving knn_core enable/sample and returning
// a coherent lo-then-hi snapshot of its 2*DATA_W value.
`timescale 1ns/1ps
module knn_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                knn_enable,
    output logic                knn_sample,
    input  logic [2*DATA_W-1:0] knn_value
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LO     = 2'd1;
    localparam logic [1:0] A_HI     = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_enable;
    logic [2*DATA_W-1:0] r_snapshot;
    logic [DATA_W-1:0]   r_shadow_hi;
    logic                r_snap_valid;

    logic [1:0]          w_reg;
    logic                w_write;
    logic                w_busy;
    logic                w_stallable;
    logic                w_accept;
    logic                w_ctrl_wr;
    logic                w_lo_rd;
    logic                w_sample_req;
    logic                w_sample;
    logic                w_capture;
    logic [DATA_W-1:0]   w_rdata_next;
    logic                w_unused;

    assign w_reg        = address[1:0];
    assign w_write      = |wstrb;
    assign w_busy       = (r_state != S_IDLE);
    // STATUS reads and no-op accesses never stall; anything touching the sampler does.
    assign w_stallable  = w_write ? (w_reg == A_CTRL) : ((w_reg == A_LO) || (w_reg == A_HI));
    assign w_accept     = valid && !r_ready && !(w_stallable && w_busy);
    assign w_ctrl_wr    = w_accept && w_write && (w_reg == A_CTRL);
    assign w_lo_rd      = w_accept && !w_write && (w_reg == A_LO);
    assign w_sample_req = w_ctrl_wr && wdata[1];
    assign w_capture    = (r_state == S_WAIT);
    assign w_unused     = ^{address, wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sample_req) begin
                    w_state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                w_sample     = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rdata_next = '0;
        if (!w_write) begin
            case (w_reg)
                A_LO:     w_rdata_next = r_snapshot[DATA_W-1:0];
                A_HI:     w_rdata_next = r_shadow_hi;
                A_STATUS: w_rdata_next = {{(DATA_W-3){1'b0}}, w_busy, r_snap_valid, r_enable};
                default:  w_rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_accept;
            if (w_accept) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    // shadow_hi only moves on a VALUE_LO read, so a later sample cannot tear a lo/hi pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable     <= 1'b0;
            r_snapshot   <= '0;
            r_shadow_hi  <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= wdata[0];
            end
            if (w_sample_req) begin
                r_snap_valid <= 1'b0;
            end else if (w_capture) begin
                r_snapshot   <= knn_value;
                r_snap_valid <= 1'b1;
            end
            if (w_lo_rd) begin
                r_shadow_hi <= r_snapshot[2*DATA_W-1:DATA_W];
            end
        end
    end

    assign rdata      = r_rdata;
    assign ready      = r_ready;
    assign knn_enable = r_enable;
    assign knn_sample = w_sample;

endmodule
